// File: rtl/detector_scheduler.sv
// Round-robin scheduler that time-shares one serial "1101" Moore detector:
// grants a requester, clears the detector, shifts its word MSB first and reports hits.
module detector_scheduler #(
  parameter int N_REQ      = 4,
  parameter int WORD_W     = 8,
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = $clog2(WORD_W + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WORD_W-1:0]  word_in,
  output logic [N_REQ-1:0]         grant,
  output logic                     det_bit,
  output logic                     det_reset,
  input  logic                     det_flag,
  output logic                     done,
  output logic [$clog2(N_REQ)-1:0] done_id,
  output logic                     hit,
  output logic [CNT_W-1:0]         match_count
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int TMAX = (RST_CYCLES > WORD_W) ? RST_CYCLES : WORD_W;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_SHIFT  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic              hacc_q, hacc_d;
  logic              done_q, done_d;
  logic [ID_W-1:0]   done_id_q, done_id_d;
  logic              hit_q, hit_d;
  logic [CNT_W-1:0]  mcnt_q, mcnt_d;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   cand_idx;
  logic [WORD_W-1:0] win_word;
  int                cand;
  logic              sample;
  logic [CNT_W-1:0]  acc_upd;
  logic              hacc_upd;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= CNT_W'(WORD_W)) return v;
    return v + CNT_W'(1);
  endfunction

  // Search starts at ptr and wraps, so the first high req after ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    cand      = 0;
    win_word  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = ID_W'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == ID_W'(i)) win_word = word_in[i*WORD_W +: WORD_W];
    end
  end

  // The flag lags its bit by one cycle, so shift cycle 0 is skipped and DRAIN is sampled.
  always_comb begin
    sample   = ((state_q == S_SHIFT) && (cnt_q != '0)) || (state_q == S_DRAIN);
    acc_upd  = (sample && det_flag) ? sat_inc(acc_q) : acc_q;
    hacc_upd = hacc_q | (sample & det_flag);

    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    sr_d      = sr_q;
    grant_d   = '0;
    acc_d     = acc_q;
    hacc_d    = hacc_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    hit_d     = hit_q;
    mcnt_d    = mcnt_q;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          sr_d             = win_word;
          grant_d[win_idx] = 1'b1;
          id_d             = win_idx;
          ptr_d            = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
          cnt_d            = '0;
          state_d          = S_CLEAR;
        end
      end
      S_CLEAR: begin
        acc_d  = '0;
        hacc_d = 1'b0;
        if (cnt_q == TW'(RST_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_SHIFT: begin
        acc_d  = acc_upd;
        hacc_d = hacc_upd;
        sr_d   = {sr_q[WORD_W-2:0], 1'b0};
        if (cnt_q == TW'(WORD_W - 1)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_DRAIN: begin
        acc_d     = acc_upd;
        hacc_d    = hacc_upd;
        done_d    = 1'b1;
        done_id_d = id_q;
        hit_d     = hacc_upd;
        mcnt_d    = acc_upd;
        state_d   = S_REPORT;
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      id_q      <= '0;
      sr_q      <= '0;
      grant_q   <= '0;
      acc_q     <= '0;
      hacc_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      hit_q     <= 1'b0;
      mcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      sr_q      <= sr_d;
      grant_q   <= grant_d;
      acc_q     <= acc_d;
      hacc_q    <= hacc_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      hit_q     <= hit_d;
      mcnt_q    <= mcnt_d;
    end
  end

  // Detector is held in reset everywhere except while bits are being streamed.
  assign det_reset   = !((state_q == S_SHIFT) || (state_q == S_DRAIN));
  assign det_bit     = (state_q == S_SHIFT) && sr_q[WORD_W-1];
  assign grant       = grant_q;
  assign done        = done_q;
  assign done_id     = done_id_q;
  assign hit         = hit_q;
  assign match_count = mcnt_q;

endmodule

// File: tb/tb_detector_scheduler.sv
// Scoreboard bench for detector_scheduler with a behavioural "1101" Moore detector model.
module tb_detector_scheduler;
  localparam int N_REQ      = 4;
  localparam int WORD_W     = 8;
  localparam int RST_CYCLES = 2;
  localparam int CNT_W      = $clog2(WORD_W + 1);
  localparam int ID_W       = $clog2(N_REQ);
  localparam int PERIOD     = RST_CYCLES + WORD_W + 3;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic [N_REQ-1:0]        req = '0;
  logic [N_REQ*WORD_W-1:0] word_in = '0;
  logic [N_REQ-1:0]        grant;
  logic                    det_bit;
  logic                    det_reset;
  logic                    det_flag;
  logic                    done;
  logic [ID_W-1:0]         done_id;
  logic                    hit;
  logic [CNT_W-1:0]        match_count;

  typedef struct {
    int id;
    int h;
    int c;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   grant_cnt[N_REQ];
  int   grant_id_log[$];
  int   grant_cyc_log[$];
  int   dr_run = 0;
  int   dr_min = 1000;
  logic [2:0] dstate = 3'd0;

  detector_scheduler #(
    .N_REQ(N_REQ), .WORD_W(WORD_W), .RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .word_in(word_in), .grant(grant),
    .det_bit(det_bit), .det_reset(det_reset), .det_flag(det_flag), .done(done),
    .done_id(done_id), .hit(hit), .match_count(match_count)
  );

  always #5 clock = ~clock;

  // Overlapping "1101" Moore detector, synchronous active-high reset.
  always @(posedge clock) begin
    if (det_reset) dstate <= 3'd0;
    else begin
      case (dstate)
        3'd0:    dstate <= det_bit ? 3'd1 : 3'd0;
        3'd1:    dstate <= det_bit ? 3'd2 : 3'd0;
        3'd2:    dstate <= det_bit ? 3'd2 : 3'd3;
        3'd3:    dstate <= det_bit ? 3'd4 : 3'd0;
        default: dstate <= det_bit ? 3'd2 : 3'd0;
      endcase
    end
  end
  assign det_flag = (dstate == 3'd4);

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done and logs grants / det_reset runs.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done with id %0d, expected no done", done_id);
        end else begin
          e = sb_q.pop_front();
          check("done_id", 32'(done_id), e.id);
          check("hit", 32'(hit), e.h);
          check("match_count", 32'(match_count), e.c);
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i]) begin
          grant_cnt[i]++;
          grant_id_log.push_back(i);
          grant_cyc_log.push_back(cyc);
        end
      end
      if (det_reset) dr_run++;
      else begin
        if (dr_run > 0 && dr_run < dr_min) dr_min = dr_run;
        dr_run = 0;
      end
    end
  end

  // Called at a negedge while the DUT is idle; returns at the negedge of the next idle cycle.
  task automatic run_frame(input int idx, input logic [WORD_W-1:0] w, input int eh, input int ec);
    logic [WORD_W-1:0]            bits;
    logic [RST_CYCLES+WORD_W:0]   rpat;
    logic                         dn;
    logic                         drain_bit;
    bits = '0; rpat = '0; dn = 1'b0; drain_bit = 1'b0;
    req[idx] = 1'b1;
    word_in[idx*WORD_W +: WORD_W] = w;
    sb_q.push_back('{idx, eh, ec});
    @(negedge clock);
    check("grant_onehot", 32'(grant), 32'(1) << idx);
    req[idx] = 1'b0;
    for (int c = 1; c <= RST_CYCLES + WORD_W + 1; c++) begin
      if (c > 1) @(negedge clock);
      rpat[c-1] = det_reset;
      dn = dn | done;
      if (c > RST_CYCLES && c <= RST_CYCLES + WORD_W) bits[WORD_W-1-(c-RST_CYCLES-1)] = det_bit;
      if (c == RST_CYCLES + WORD_W + 1) drain_bit = det_bit;
    end
    check("det_bit_seq", 32'(bits), 32'(w));
    check("det_reset_pattern", 32'(rpat), (32'(1) << RST_CYCLES) - 1);
    check("drain_bit_low", 32'(drain_bit), 0);
    check("done_early", 32'(dn), 0);
    @(negedge clock);
    check("done_pulse", 32'(done), 1);
    @(negedge clock);
    check("done_one_cycle", 32'(done), 0);
    check("done_id_held", 32'(done_id), idx);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int g2, g3, n0;
    int rr_exp[5];
    rr_exp = '{0, 1, 2, 3, 0};

    repeat (3) @(negedge clock);
    check("rst_grant", 32'(grant), 0);
    check("rst_det_bit", 32'(det_bit), 0);
    check("rst_det_reset", 32'(det_reset), 1);
    check("rst_done", 32'(done), 0);
    check("rst_done_id", 32'(done_id), 0);
    check("rst_hit", 32'(hit), 0);
    check("rst_match_count", 32'(match_count), 0);
    reset = 1'b1;
    @(negedge clock);

    run_frame(1, 8'b1101_0000, 1, 1);
    run_frame(0, 8'h00, 0, 0);
    run_frame(0, 8'b1100_0100, 0, 0);
    run_frame(3, 8'b1101_1101, 1, 2);

    // Withdraw and ignore: req[2] pulsed mid-frame, req[3] dropped in the idle cycle.
    g2 = grant_cnt[2];
    g3 = grant_cnt[3];
    req[0] = 1'b1;
    word_in[0 +: WORD_W] = 8'h00;
    sb_q.push_back('{0, 0, 0});
    @(negedge clock);
    req[0] = 1'b0;
    req[3] = 1'b1;
    repeat (4) @(negedge clock);
    req[2] = 1'b1;
    repeat (2) @(negedge clock);
    req[2] = 1'b0;
    repeat (6) @(negedge clock);
    req[3] = 1'b0;
    repeat (20) @(negedge clock);
    check("withdrawn_req2_grants", g2 == grant_cnt[2] ? 0 : grant_cnt[2] - g2, 0);
    check("withdrawn_req3_grants", g3 == grant_cnt[3] ? 0 : grant_cnt[3] - g3, 0);
    check("withdraw_frame_done", sb_q.size(), 0);

    // Round robin with all requests held from reset.
    reset = 1'b0;
    req = '1;
    word_in = {8'h0D, 8'h00, 8'hDD, 8'hD0};
    sb_q.push_back('{0, 1, 1});
    sb_q.push_back('{1, 1, 2});
    sb_q.push_back('{2, 0, 0});
    sb_q.push_back('{3, 1, 1});
    sb_q.push_back('{0, 1, 1});
    @(negedge clock);
    n0 = grant_id_log.size();
    dr_min = 1000;
    dr_run = 0;
    reset = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      #1;
      if (grant_id_log.size() >= n0 + 5) break;
    end
    req = '0;
    check("rr_grant_count", grant_id_log.size() - n0, 5);
    if (grant_id_log.size() >= n0 + 5) begin
      for (int i = 0; i < 5; i++) begin
        check("rr_grant_order", grant_id_log[n0+i], rr_exp[i]);
        if (i > 0) check("rr_grant_spacing", grant_cyc_log[n0+i] - grant_cyc_log[n0+i-1], PERIOD);
      end
    end
    repeat (20) @(negedge clock);
    check("rr_all_done", sb_q.size(), 0);
    check("rr_det_reset_min_run", dr_min >= RST_CYCLES ? 1 : 0, 1);

    // Abort a frame with async reset in shift cycle 4.
    req[1] = 1'b1;
    word_in[WORD_W +: WORD_W] = 8'hDD;
    @(negedge clock);
    req[1] = 1'b0;
    repeat (6) @(negedge clock);
    check("abort_in_shift", 32'(det_reset), 0);
    #2;
    reset = 1'b0;
    #1;
    check("abort_det_reset", 32'(det_reset), 1);
    check("abort_grant", 32'(grant), 0);
    check("abort_done", 32'(done), 0);
    check("abort_det_bit", 32'(det_bit), 0);
    check("abort_hit", 32'(hit), 0);
    check("abort_match_count", 32'(match_count), 0);
    check("abort_done_id", 32'(done_id), 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_frame(2, 8'b1101_0000, 1, 1);
    repeat (5) @(negedge clock);
    check("final_scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
